inv_mix_columns_seq: RTL
========================

// Module: inv_mix_columns_seq
// PURPOSE
//  Iterative AES InvMixColumns unit for the decryption datapath.
//  Inverse of the encryption-side MixColumns stage.
//  Takes one 128-bit state per valid/ready transaction and transforms COLS_PER_CYCLE columns per clock.
//  Holds the result until the downstream stage (InvShiftRows/AddRoundKey) accepts it.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    in_data is valid
//  in_ready   out  1    block can accept a state
//  in_data    in   128  input state; column c = in_data[127-32c -: 32], row 0 byte = column MSB
//  out_valid  out  1    out_data holds a finished state
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  InvMixColumns(in_data), same byte layout as in_data
//  busy       out  1    high in BUSY state
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, col_cnt=0, out_valid=0, out_data=0, in_ready=1, busy=0.
//  - States: IDLE, BUSY, DONE.
//    IDLE: in_ready=1. On in_valid&&in_ready, load work_reg<=in_data, col_cnt<=0, and go to BUSY.
//    BUSY: in_ready=0. Each cycle replaces columns col_cnt..col_cnt+C-1 of work_reg in place,
//          then col_cnt+=C. After the last group, go to DONE.
//    DONE: out_valid=1, out_data=work_reg, held stable while out_ready=0.
//          On out_ready, go to IDLE.
//  - Latency: accept edge to out_valid is 4/C cycles (C=1:4, C=2:2, C=4:1).
//  - No overlap: in_ready=0 in BUSY and DONE; a new state is accepted in the cycle after the handshake.
//  - col_cnt is 2 bits and wraps naturally; it is reset to 0 on every accept.
//  - Per column, with inputs a0..a3 (a0 = MSB byte), all in GF(2^8) modulo 0x11b:
//      b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
//      b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
//      b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
//      b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
//  - Multiplication: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
//      09 = x8^x;  0b = x8^x2^x;  0d = x8^x4^x;  0e = x8^x4^x2.
//    Results are 8 bits, with no carry out.
//  - Held inputs: in_valid high in BUSY/DONE is ignored; data is not consumed until IDLE.
//  - Output held: out_ready high outside DONE has no effect.
//  - Reset mid-operation discards the in-flight state. No output is produced for it.
//  - out_data changes only on entry to DONE. It is don't-care outside DONE but must not be X after reset.
// STRUCTURE
//  - Package aes_inv_pkg:
//      state enum {IDLE, BUSY, DONE}
//      localparams for the coefficients 8'h0e, 8'h0b, 8'h0d, 8'h09
//      functions xtime() and gmul_const()
//  - Sub-module inv_mix_column: combinational, 32-bit column in and 32-bit column out.
//    Instantiated COLS_PER_CYCLE times; column select via col_cnt.
//  - Top level holds the FSM, col_cnt, work_reg and the handshake logic.
// TESTING
//  1. Single column, C=1:
//     in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     -> out_data = db135345_f20a225c_01010101_c6c6c6c6
//     -> out_valid rises 4 cycles after accept.
//  2. Round trip: d5d5d7d6_4d7ebdf8_00000000_ffffffff
//     -> d4d4d4d5_2d26314c_00000000_ffffffff
//     Repeat with C=2 (latency 2) and C=4 (latency 1).
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE
//     -> out_valid and out_data stable, in_ready=0.
//     Then release -> one handshake, return to IDLE, in_ready=1.
//  4. Back-to-back: in_valid held high with two states, out_ready=1
//     -> both transformed correctly, in order.
//     Second accept occurs the cycle after the first output handshake.
//  5. Reset in BUSY after 2 columns
//     -> out_valid=0, in_ready=1 immediately. No output for the aborted state.
//     The next state is transformed correctly.
//  6. Random: 1000 random states with random valid/ready gaps
//     -> compared against the golden model inv(MixColumns(x)) == x.

Source files
------------

// File: rtl/inv_mix_columns_seq_pkg.sv
// rtl/inv_mix_columns_seq_pkg.sv - AES InvMixColumns types, coefficients and GF(2^8) helpers
package aes_inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] COEF_0E = 8'h0e;
  localparam logic [7:0] COEF_0B = 8'h0b;
  localparam logic [7:0] COEF_0D = 8'h0d;
  localparam logic [7:0] COEF_09 = 8'h09;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the four InvMixColumns coefficients are supported; anything else yields 0.
  function automatic logic [7:0] gmul_const(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] x2, x4, x8, r;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      COEF_09: r = x8 ^ x;
      COEF_0B: r = x8 ^ x2 ^ x;
      COEF_0D: r = x8 ^ x4 ^ x;
      COEF_0E: r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - state in/out handshake bundle for inv_mix_columns_seq
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_mix_columns_seq_col.sv
// rtl/inv_mix_columns_seq_col.sv - combinational InvMixColumns on one 32-bit column
module inv_mix_column
  import aes_inv_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  assign col_o[31:24] = gmul_const(a0, COEF_0E) ^ gmul_const(a1, COEF_0B) ^
                        gmul_const(a2, COEF_0D) ^ gmul_const(a3, COEF_09);
  assign col_o[23:16] = gmul_const(a0, COEF_09) ^ gmul_const(a1, COEF_0E) ^
                        gmul_const(a2, COEF_0B) ^ gmul_const(a3, COEF_0D);
  assign col_o[15:8]  = gmul_const(a0, COEF_0D) ^ gmul_const(a1, COEF_09) ^
                        gmul_const(a2, COEF_0E) ^ gmul_const(a3, COEF_0B);
  assign col_o[7:0]   = gmul_const(a0, COEF_0B) ^ gmul_const(a1, COEF_0D) ^
                        gmul_const(a2, COEF_09) ^ gmul_const(a3, COEF_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative InvMixColumns, COLS_PER_CYCLE columns per clock
module inv_mix_columns_seq
  import aes_inv_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_seq_if.slave  bus,
  output logic                  busy
);

  localparam int         C        = COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(4 - C);
  localparam logic [1:0] CNT_STEP = 2'(C);

  if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t           state_q, state_d;
  logic [1:0]       col_cnt_q, col_cnt_d;
  // Packed index 3-c holds column c, so column c is work_q[~c].
  logic [3:0][31:0] work_q, work_d;
  logic [127:0]     out_data_q, out_data_d;
  logic [1:0]       col_idx [C];
  logic [31:0]      col_in  [C];
  logic [31:0]      col_out [C];
  logic             last_grp;

  assign last_grp = (col_cnt_q == LAST_GRP);

  for (genvar j = 0; j < C; j++) begin : g_col
    assign col_idx[j] = col_cnt_q + 2'(j);
    assign col_in[j]  = work_q[~col_idx[j]];

    inv_mix_column u_col (
      .col_i (col_in[j]),
      .col_o (col_out[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_grp)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q == BUSY);
  end

  assign bus.out_data = out_data_q;

  always_comb begin
    work_d     = work_q;
    col_cnt_d  = col_cnt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d    = bus.in_data;
          col_cnt_d = 2'd0;
        end
      end
      BUSY: begin
        for (int j = 0; j < C; j++) begin
          work_d[~col_idx[j]] = col_out[j];
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        // Output register captures only on entry to DONE so out_data never ripples.
        if (last_grp) begin
          out_data_d = work_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q     <= '0;
      col_cnt_q  <= 2'd0;
      out_data_q <= '0;
    end else begin
      work_q     <= work_d;
      col_cnt_q  <= col_cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
